// File: rtl/sram_like_arbiter.sv
// rtl/sram_like_arbiter.sv - shares one SRAM-like memory port between inst and data requesters
// Data has priority; inst is forced through after STARVE_LIMIT consecutive data grants.
module sram_like_arbiter #(
   parameter int STARVE_LIMIT = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        inst_req,
   input  logic        inst_wr,
   input  logic [1:0]  inst_size,
   input  logic [31:0] inst_addr,
   input  logic [31:0] inst_wdata,
   input  logic        inst_uncached,
   output logic [31:0] inst_rdata,
   output logic        inst_addr_ok,
   output logic        inst_data_ok,
   input  logic        data_req,
   input  logic        data_wr,
   input  logic [1:0]  data_size,
   input  logic [31:0] data_addr,
   input  logic [31:0] data_wdata,
   input  logic        data_uncached,
   output logic [31:0] data_rdata,
   output logic        data_addr_ok,
   output logic        data_data_ok,
   output logic        mem_req,
   output logic        mem_wr,
   output logic [1:0]  mem_size,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic        mem_uncached,
   input  logic [31:0] mem_rdata,
   input  logic        mem_addr_ok,
   input  logic        mem_data_ok,
   output logic        busy
);

   localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

   typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

   state_t     state;
   logic       owner;
   logic [3:0] streak;
   logic       arb_now;
   logic       pick_data;
   logic       pick_inst;
   logic       in_addr;
   logic       in_data;

   always_comb begin
      in_addr   = (state == ADDR);
      in_data   = (state == DATA);
      // Re-arbitrating on the completing cycle avoids an IDLE bubble between transactions.
      arb_now   = (state == IDLE) || (in_data && mem_data_ok);
      pick_data = data_req && !(inst_req && (streak == LIMIT));
      pick_inst = inst_req && !pick_data;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         owner  <= 1'b0;
         streak <= 4'd0;
      end else begin
         case (state)
            ADDR: begin
               if (mem_addr_ok)
                  state <= DATA;
            end
            default: begin
               if (arb_now) begin
                  if (pick_data) begin
                     owner <= 1'b1;
                     state <= ADDR;
                     if (inst_req)
                        streak <= (streak == 4'hf) ? streak : streak + 4'd1;
                     else
                        streak <= 4'd0;
                  end else if (pick_inst) begin
                     owner  <= 1'b0;
                     state  <= ADDR;
                     streak <= 4'd0;
                  end else begin
                     state <= IDLE;
                  end
               end
            end
         endcase
      end
   end

   always_comb begin
      mem_req      = in_addr;
      mem_wr       = in_addr & (owner ? data_wr : inst_wr);
      mem_size     = in_addr ? (owner ? data_size : inst_size) : 2'd0;
      mem_addr     = in_addr ? (owner ? data_addr : inst_addr) : 32'd0;
      mem_wdata    = in_addr ? (owner ? data_wdata : inst_wdata) : 32'd0;
      mem_uncached = in_addr & (owner ? data_uncached : inst_uncached);
      inst_addr_ok = in_addr & ~owner & mem_addr_ok;
      data_addr_ok = in_addr & owner & mem_addr_ok;
      inst_data_ok = in_data & ~owner & mem_data_ok;
      data_data_ok = in_data & owner & mem_data_ok;
      inst_rdata   = mem_rdata;
      data_rdata   = mem_rdata;
      busy         = (state != IDLE);
   end

endmodule

// File: doc/sram_like_arbiter.md
Name: sram_like_arbiter

Overview:
- Shares one SRAM-like memory port between the core's instruction and data requesters.
- The upstream inst_* and data_* buses use the same req/wr/size/addr/wdata/rdata/addr_ok/data_ok/uncached protocol the core already drives.
- Sits between the mips core and a single-port cache/AXI adapter, so the adapter needs only one request channel.
- Data has priority, bounded by an anti-starvation limit for instruction fetch.

Parameters:
- STARVE_LIMIT, 4, consecutive data grants allowed while inst_req is pending before inst is forced to win; legal range 1..15.

Ports:
- clk  in  1  clock; all state on rising edge
- rst  in  1  synchronous, active-high reset
- inst_req  in  1  instruction request, held until inst_addr_ok
- inst_wr  in  1  write flag
- inst_size  in  2  transfer size (0=byte, 1=half, 2=word)
- inst_addr  in  32  physical address
- inst_wdata  in  32  write data
- inst_uncached  in  1  uncached attribute
- inst_rdata  out  32  read data, valid with inst_data_ok
- inst_addr_ok  out  1  request accepted
- inst_data_ok  out  1  transaction complete
- data_req, data_wr, data_size, data_addr, data_wdata, data_uncached  in  1/1/2/32/32/1  same meaning for the data requester
- data_rdata  out  32; data_addr_ok  out  1; data_data_ok  out  1
- mem_req  out  1  downstream request
- mem_wr  out  1; mem_size  out  2; mem_addr  out  32; mem_wdata  out  32; mem_uncached  out  1
- mem_rdata  in  32; mem_addr_ok  in  1; mem_data_ok  in  1
- busy  out  1  high when the state is not IDLE

Behaviour:
- Exactly one transaction is outstanding downstream at a time.
- State machine: IDLE, ADDR, DATA. Register owner (0=inst, 1=data); 4-bit streak counter.
- Arbitration (evaluated in IDLE, and in DATA on the cycle mem_data_ok=1):
  - Only data_req: data wins.
  - Only inst_req: inst wins.
  - Both: data wins unless streak == STARVE_LIMIT, in which case inst wins.
  - The winner is latched into owner; next state is ADDR. With no request, next state is IDLE.
- Streak update at each grant:
  - Data granted while inst_req=1: streak+1, saturating at 15.
  - Inst granted, or data granted with inst_req=0: streak=0.
- ADDR:
  - mem_req=1; mem_wr/size/addr/wdata/uncached are muxed from the owner's live inputs.
  - owner_addr_ok = mem_addr_ok combinationally; the non-owner's addr_ok = 0.
  - On mem_addr_ok=1, go to DATA.
  - The owner must hold its request stable until addr_ok; this is a requester obligation and is not checked.
- DATA:
  - mem_req=0.
  - owner_data_ok = mem_data_ok combinationally.
  - On mem_data_ok=1, re-arbitrate the same cycle: go to ADDR with the new owner, else to IDLE. Back-to-back throughput is therefore one accepted request per (1 + downstream latency) cycles, with no IDLE bubble.
- inst_rdata and data_rdata are both wired to mem_rdata; each is meaningful only with its own data_ok.
- Outside ADDR, mem_wr/size/addr/wdata/uncached are driven to 0.
- A requester never sees addr_ok on the same cycle it is first granted. Minimum request-to-addr_ok latency is 1 cycle (grant) + 0 (if the downstream accepts immediately).
- Spurious inputs:
  - mem_addr_ok outside ADDR is ignored.
  - mem_data_ok outside DATA is ignored and not forwarded.
  - A requester that drops req while in ADDR is not protected against; owner is unaffected until addr_ok.
- Reset, including mid-transaction:
  - State=IDLE, owner=0, streak=0.
  - mem_req=0, all addr_ok/data_ok=0, busy=0.
  - Any in-flight downstream transaction is abandoned; the downstream is reset by the same rst.

Test Plan:
- inst_req only, addr 0xBFC00000, word read; mem_addr_ok high after 2 cycles, mem_data_ok after 3 more with rdata 0x3C1D0000 -> grant in cycle 1, inst_addr_ok coincides with mem_addr_ok, inst_data_ok with inst_rdata=0x3C1D0000; data_* outputs stay 0; busy returns to 0.
- inst_req and data_req asserted together, single request each -> data granted first (mem_addr=data_addr), inst granted in the same cycle as the data's mem_data_ok, with no IDLE cycle between them.
- data_req held continuously (a new request after each data_ok) with inst_req held, STARVE_LIMIT=4 -> grant sequence D,D,D,D,I,D,D,D,D,I; streak resets to 0 after each inst grant.
- Data write 0xDEADBEEF, size=2, uncached=1, addr 0x1FAF0000 -> mem_wr=1, mem_wdata=0xDEADBEEF, mem_uncached=1 during ADDR only; all fields are 0 in DATA and IDLE.
- mem_data_ok pulsed in IDLE and in ADDR -> neither inst_data_ok nor data_data_ok asserts, and the state is unchanged.
- rst asserted during DATA of an inst read -> next cycle state=IDLE, mem_req=0, busy=0, streak=0; a later mem_data_ok is ignored; a fresh data_req is granted normally.
